delta_decompressor: RTL and testbench

Reconstructs the original N-lane vector stream from trace-buffer entries written by the delta compressor. It sits on the trace-buffer readout path and walks entries newest-to-oldest. It is seeded with the compressor's final `last_vector_out` and emits one full vector per handshake, newest first. Compressed entries expand into up to DELTA_SLOTS vectors. Raw entries replace the running vector directly.

---
 rtl/delta_pkg.sv | 41 ++++
 rtl/delta_slot_unpack.sv | 54 +++++
 rtl/delta_decompressor.sv | 122 ++++++++++++
 tb/tb_delta_decompressor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delta_pkg.sv
// Shared types and slot helpers for the delta decompressor.
// Slot 0 is the MSB slot; the INV pattern (sign bit only) marks an empty slot.
package delta_pkg;

    localparam int MAXW = 64;
    typedef logic [MAXW-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_FETCH,
        ST_EXPAND,
        ST_RAW
    } state_e;

    function automatic int precision(input int dw, input int ds);
        return dw / ds;
    endfunction

    function automatic word_t inv_pat(input int prec);
        return word_t'(1) << (prec - 1);
    endfunction

    function automatic word_t nodata(input int dw, input int prec);
        word_t r = '0;
        for (int s = 0; s < dw / prec; s++) r |= inv_pat(prec) << (s * prec);
        return r;
    endfunction

    function automatic word_t slot_field(input word_t word, input int s, input int dw, input int prec);
        return (word >> (dw - (s + 1) * prec)) & ((word_t'(1) << prec) - word_t'(1));
    endfunction

    // The INV pattern is exactly the slot's sign bit, so it doubles as the extension test.
    function automatic word_t slot_sext(input word_t word, input int s, input int dw, input int prec);
        word_t m = (word_t'(1) << prec) - word_t'(1);
        word_t f = slot_field(word, s, dw, prec);
        return ((f & inv_pat(prec)) != '0) ? (f | ~m) : f;
    endfunction

endpackage

// File: rtl/delta_slot_unpack.sv
// Valid-slot count from lane 0 of an entry; with DELTA_DECOMP_CHECK_EN it also
// flags non-prefix slots or lanes whose INV layout disagrees with lane 0.
module delta_slot_unpack
    import delta_pkg::*;
#(
    parameter int N           = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DELTA_SLOTS = 4,
    parameter int KW          = $clog2(DELTA_SLOTS + 1)
) (
    input  logic [N-1:0][DATA_WIDTH-1:0] entry_i,
    output logic [KW-1:0]                k_o,
    output logic                         err_o
);

    localparam int    PREC = precision(DATA_WIDTH, DELTA_SLOTS);
    localparam word_t INV  = inv_pat(PREC);

    logic [DELTA_SLOTS-1:0] inv0;
    logic                   stop;
    int                     cnt;

    always_comb begin
        cnt  = 0;
        stop = 1'b0;
        for (int s = 0; s < DELTA_SLOTS; s++) begin
            inv0[s] = (slot_field(word_t'(entry_i[0]), s, DATA_WIDTH, PREC) == INV);
            if (inv0[s]) stop = 1'b1;
            else if (!stop) cnt++;
        end
    end

`ifdef DELTA_DECOMP_CHECK_EN
    logic bad;

    always_comb begin
        bad = 1'b0;
        for (int s = 0; s < DELTA_SLOTS; s++)
            if (s >= cnt && !inv0[s]) bad = 1'b1;
        for (int l = 0; l < N; l++)
            for (int s = 0; s < DELTA_SLOTS; s++)
                if ((slot_field(word_t'(entry_i[l]), s, DATA_WIDTH, PREC) == INV) != inv0[s]) bad = 1'b1;
    end

    assign err_o = bad;
    assign k_o   = bad ? '0 : KW'(cnt);
`else
    logic unused_lanes;
    assign unused_lanes = ^entry_i;
    assign err_o        = 1'b0;
    assign k_o          = KW'(cnt);
`endif

endmodule

// File: rtl/delta_decompressor.sv
// Walks trace-buffer entries newest-to-oldest, re-expanding delta slots into full vectors.
// Optional malformed-entry checking is enabled by defining DELTA_DECOMP_CHECK_EN.
module delta_decompressor
    import delta_pkg::*;
#(
    parameter int N           = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DELTA_SLOTS = 4,
    parameter int COMPRESSED  = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [N-1:0][DATA_WIDTH-1:0] seed_in,
    input  logic                         entry_valid_in,
    output logic                         entry_ready_out,
    input  logic [N-1:0][DATA_WIDTH-1:0] entry_in,
    input  logic                         compression_flag_in,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
    output logic                         busy_out,
    output logic                         error_out
);

    localparam int PREC = precision(DATA_WIDTH, DELTA_SLOTS);
    localparam int KW   = $clog2(DELTA_SLOTS + 1);
    localparam int SW   = (DELTA_SLOTS > 1) ? $clog2(DELTA_SLOTS) : 1;

    state_e                        state_q;
    logic [N-1:0][DATA_WIDTH-1:0]  vec_q, run_q, ent_q, step_vec;
    logic [SW-1:0]                 slot_q, step_slot;
    logic                          valid_q, ready_q, err_q;
    logic [KW-1:0]                 k_w;
    logic                          unp_err, in_fetch, comp, hs, accept;

    delta_slot_unpack #(
        .N(N), .DATA_WIDTH(DATA_WIDTH), .DELTA_SLOTS(DELTA_SLOTS), .KW(KW)
    ) u_unpack (
        .entry_i(entry_in),
        .k_o    (k_w),
        .err_o  (unp_err)
    );

    assign in_fetch  = (state_q == ST_FETCH);
    assign comp      = (compression_flag_in == 1'(COMPRESSED));
    assign hs        = valid_q & ready_in;
    assign accept    = ready_q & entry_valid_in;
    // On accept the first step works from the incoming entry; afterwards from the latched one.
    assign step_slot = in_fetch ? SW'(k_w - KW'(1)) : slot_q - SW'(1);

    for (genvar l = 0; l < N; l++) begin : g_lane
        assign step_vec[l] = (in_fetch ? run_q[l] : vec_q[l])
            + DATA_WIDTH'(slot_sext(word_t'(in_fetch ? entry_in[l] : ent_q[l]),
                                    int'(step_slot), DATA_WIDTH, PREC));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            run_q   <= '0;
            ent_q   <= '0;
            slot_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (start) begin
            state_q <= ST_SEED;
            vec_q   <= seed_in;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_SEED, ST_RAW: if (hs) begin
                    run_q   <= vec_q;
                    state_q <= ST_FETCH;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
                ST_FETCH: if (accept) begin
                    if (!comp) begin
                        vec_q   <= entry_in;
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= ST_RAW;
                    end else begin
                        if (unp_err) err_q <= 1'b1;
                        if (k_w != '0) begin
                            ent_q   <= entry_in;
                            slot_q  <= step_slot;
                            vec_q   <= step_vec;
                            valid_q <= 1'b1;
                            ready_q <= 1'b0;
                            state_q <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: if (hs) begin
                    run_q <= vec_q;
                    if (slot_q == '0) begin
                        state_q <= ST_FETCH;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        slot_q <= step_slot;
                        vec_q  <= step_vec;
                    end
                end
                default: ;
            endcase
        end
    end

    assign entry_ready_out = ready_q;
    assign valid_out       = valid_q;
    assign vector_out      = vec_q;
    assign busy_out        = (state_q != ST_IDLE);
    assign error_out       = err_q;

endmodule

// File: tb/tb_delta_decompressor.sv
// Randomized bench for delta_decompressor against a queue-based reconstruction model.
module tb_delta_decompressor;

    localparam int N = 8, DW = 32, DS = 4, PREC = 8;
    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef logic [255:0]         w_t;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic entry_valid_in = 1'b0, compression_flag_in = 1'b0, ready_in = 1'b0;
    vec_t seed_in = '0, entry_in = '0;
    logic entry_ready_out, valid_out, busy_out, error_out;
    vec_t vector_out;

    int   checks = 0, errors = 0;
    vec_t ents[$];
    bit   flg[$];
    vec_t exp_q[$];
    int   exp_cyc;

    always #5 clk = ~clk;

    delta_decompressor #(.N(N), .DATA_WIDTH(DW), .DELTA_SLOTS(DS), .COMPRESSED(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .seed_in(seed_in),
        .entry_valid_in(entry_valid_in), .entry_ready_out(entry_ready_out),
        .entry_in(entry_in), .compression_flag_in(compression_flag_in),
        .valid_out(valid_out), .ready_in(ready_in), .vector_out(vector_out),
        .busy_out(busy_out), .error_out(error_out)
    );

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t splat(input logic [31:0] v);
        vec_t r;
        for (int l = 0; l < N; l++) r[l] = v;
        return r;
    endfunction

    function automatic logic [7:0] slot_of(input logic [31:0] w, input int s);
        logic [31:0] t = w >> (DW - PREC * (s + 1));
        return t[7:0];
    endfunction

    // Expected output sequence and ideal cycle count for the current entry list.
    task automatic build_model(input vec_t seed);
        vec_t run = seed;
        exp_q.delete();
        exp_q.push_back(run);
        exp_cyc = 1;
        foreach (ents[i]) begin
            if (flg[i] != 1'b0) begin
                run = ents[i];
                exp_q.push_back(run);
                exp_cyc += 2;
            end else begin
                int k = 0;
                while (k < DS && slot_of(ents[i][0], k) != 8'h80) k++;
                for (int s = k - 1; s >= 0; s--) begin
                    for (int l = 0; l < N; l++) begin
                        int d;
                        d = int'($signed(slot_of(ents[i][l], s)));
                        run[l] = run[l] + 32'(d);
                    end
                    exp_q.push_back(run);
                end
                exp_cyc += k + 1;
            end
        end
    endtask

    task automatic gen(input int n);
        ents.delete();
        flg.delete();
        repeat (n) begin
            vec_t e;
            int k;
            logic [7:0] b;
            if ($urandom_range(3) == 0) begin
                for (int l = 0; l < N; l++) e[l] = $urandom;
                flg.push_back(1'b1);
            end else begin
                k = $urandom_range(DS);
                for (int l = 0; l < N; l++)
                    for (int s = 0; s < DS; s++) begin
                        b = 8'($urandom);
                        if (b == 8'h80) b = 8'h7F;
                        e[l][DW-1-PREC*s -: PREC] = (s < k) ? b : 8'h80;
                    end
                flg.push_back(1'b0);
            end
            ents.push_back(e);
        end
    endtask

    task automatic run_walk(input vec_t seed, input int p_rdy, input int p_vld);
        int idx = 0, cyc = 0;
        build_model(seed);
        seed_in = seed;
        start = 1'b1; ready_in = 1'b0; entry_valid_in = 1'b0;
        tick;
        start = 1'b0;
        while ((idx < ents.size() || exp_q.size() > 0) && cyc < 5000) begin
            ready_in       = ($urandom_range(99) < p_rdy);
            entry_valid_in = (idx < ents.size()) && ($urandom_range(99) < p_vld);
            if (idx < ents.size()) begin
                entry_in            = ents[idx];
                compression_flag_in = flg[idx];
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) chk("extra_valid", w_t'(valid_out), w_t'(0));
                else chk("vec", w_t'(vector_out), w_t'(exp_q.pop_front()));
            end
            if (entry_ready_out && entry_valid_in) idx++;
            tick;
            cyc++;
        end
        chk("pending_out", w_t'(exp_q.size()), w_t'(0));
        chk("pending_in", w_t'(ents.size() - idx), w_t'(0));
        if (p_rdy == 100 && p_vld == 100) chk("cycles", w_t'(cyc), w_t'(exp_cyc));
        entry_valid_in = 1'b0;
        ready_in = 1'b1;
        tick;
        chk("idle_valid", w_t'(valid_out), w_t'(0));
        chk("fetch_ready", w_t'(entry_ready_out), w_t'(1));
        chk("no_err", w_t'(error_out), w_t'(0));
    endtask

    initial begin
        vec_t sd, e;
        tick;
        tick;
        chk("rst_valid", w_t'(valid_out), w_t'(0));
        chk("rst_erdy", w_t'(entry_ready_out), w_t'(0));
        chk("rst_busy", w_t'(busy_out), w_t'(0));
        chk("rst_err", w_t'(error_out), w_t'(0));
        chk("rst_vec", w_t'(vector_out), w_t'(0));
        reset_n = 1'b1;
        tick;

        // Seed 100, compressed 0x05FE8080 -> 100, 98, 103 with exact cycle timing
        ready_in = 1'b1; seed_in = splat(100); start = 1'b1;
        tick;
        start = 1'b0;
        chk("seed_valid", w_t'(valid_out), w_t'(1));
        chk("seed_vec", w_t'(vector_out), w_t'(splat(100)));
        chk("busy", w_t'(busy_out), w_t'(1));
        chk("seed_erdy", w_t'(entry_ready_out), w_t'(0));
        tick;
        chk("fetch_erdy", w_t'(entry_ready_out), w_t'(1));
        chk("fetch_valid", w_t'(valid_out), w_t'(0));
        entry_in = splat(32'h05FE8080); compression_flag_in = 1'b0; entry_valid_in = 1'b1;
        tick;
        entry_valid_in = 1'b0;
        chk("exp0_vec", w_t'(vector_out), w_t'(splat(98)));
        chk("exp0_valid", w_t'(valid_out), w_t'(1));
        chk("exp_erdy", w_t'(entry_ready_out), w_t'(0));
        tick;
        chk("exp1_vec", w_t'(vector_out), w_t'(splat(103)));
        tick;
        chk("post_exp_erdy", w_t'(entry_ready_out), w_t'(1));
        chk("post_exp_valid", w_t'(valid_out), w_t'(0));
        entry_in = splat(32'h80808080); entry_valid_in = 1'b1;
        tick;
        entry_valid_in = 1'b0;
        chk("nodata_valid", w_t'(valid_out), w_t'(0));
        chk("nodata_erdy", w_t'(entry_ready_out), w_t'(1));

        // Raw 7 then compressed +1 -> 7, 8
        ents = '{splat(7), splat(32'h01808080)};
        flg  = '{1'b1, 1'b0};
        run_walk(splat(100), 100, 100);
        // Wrap-around
        ents = '{splat(32'h01808080)};
        flg  = '{1'b0};
        run_walk(splat(32'hFFFFFFFF), 100, 100);

        for (int r = 0; r < 6; r++) begin
            for (int l = 0; l < N; l++) sd[l] = $urandom;
            gen(30);
            if (r == 0) run_walk(sd, 100, 100);
            else run_walk(sd, $urandom_range(30, 100), $urandom_range(30, 100));
        end

        // Lane 3 INV layout disagrees with lane 0
        e = splat(32'h05058080);
        e[3] = 32'h05808080;
        seed_in = splat(100); ready_in = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        entry_in = e; compression_flag_in = 1'b0; entry_valid_in = 1'b1;
        tick;
        entry_valid_in = 1'b0;
`ifdef DELTA_DECOMP_CHECK_EN
        chk("chk_err", w_t'(error_out), w_t'(1));
        chk("chk_nodata_valid", w_t'(valid_out), w_t'(0));
        chk("chk_erdy", w_t'(entry_ready_out), w_t'(1));
        tick;
        chk("chk_err_sticky", w_t'(error_out), w_t'(1));
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("chk_err_clear", w_t'(error_out), w_t'(0));
`else
        chk("nochk_err", w_t'(error_out), w_t'(0));
        chk("nochk_valid", w_t'(valid_out), w_t'(1));
`endif

        // Backpressure during EXPAND, then async reset mid-EXPAND
        seed_in = splat(100); ready_in = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        entry_in = splat(32'h05FE8080); entry_valid_in = 1'b1; ready_in = 1'b0;
        tick;
        entry_valid_in = 1'b0;
        repeat (3) begin
            chk("hold_vec", w_t'(vector_out), w_t'(splat(98)));
            chk("hold_valid", w_t'(valid_out), w_t'(1));
            tick;
        end
        chk("hold_vec_end", w_t'(vector_out), w_t'(splat(98)));
        ready_in = 1'b1;
        tick;
        chk("after_hold_vec", w_t'(vector_out), w_t'(splat(103)));
        ready_in = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", w_t'(valid_out), w_t'(0));
        chk("arst_busy", w_t'(busy_out), w_t'(0));
        chk("arst_vec", w_t'(vector_out), w_t'(0));
        tick;
        reset_n = 1'b1;
        tick;

        for (int l = 0; l < N; l++) sd[l] = $urandom;
        gen(10);
        run_walk(sd, 70, 70);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
